// File: rtl/queue_ctrl_28x3.sv
// Pointer/occupancy/handshake controller for an external 28x3 1R1W storage macro.
// Read port is combinational from the macro; writes land on the clock edge.
module queue_ctrl_28x3 #(
  parameter int DEPTH = 28,
  parameter int WIDTH = 3,
  parameter int FLOW  = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_enq_valid,
  output logic             io_enq_ready,
  input  logic [WIDTH-1:0] io_enq_bits,
  output logic             io_deq_valid,
  input  logic             io_deq_ready,
  output logic [WIDTH-1:0] io_deq_bits,
  output logic [4:0]       io_count,
  output logic [4:0]       mem_W0_addr,
  output logic             mem_W0_en,
  output logic             mem_W0_clk,
  output logic [WIDTH-1:0] mem_W0_data,
  output logic [4:0]       mem_R0_addr,
  output logic             mem_R0_en,
  output logic             mem_R0_clk,
  input  logic [WIDTH-1:0] mem_R0_data
);

  localparam logic       FLOW_EN = (FLOW != 0);
  localparam logic [4:0] LAST    = 5'(DEPTH - 1);
  localparam logic [5:0] DEPTH_W = 6'(DEPTH);

  logic [4:0] enq_ptr_q, enq_ptr_d;
  logic [4:0] deq_ptr_q, deq_ptr_d;
  logic       maybe_full_q, maybe_full_d;
  logic       ptr_match, empty, full, bypass, do_enq, do_deq;
  logic [5:0] count_w;

  assign ptr_match = (enq_ptr_q == deq_ptr_q);
  assign empty     = ptr_match & ~maybe_full_q;
  assign full      = ptr_match & maybe_full_q;

  // Bypass only when empty: the enq beat goes straight out and nothing is stored.
  assign bypass       = FLOW_EN & empty & io_enq_valid & io_deq_ready;
  assign io_enq_ready = ~full;
  assign io_deq_valid = ~empty | (FLOW_EN & io_enq_valid);
  assign do_enq       = io_enq_valid & io_enq_ready & ~bypass;
  assign do_deq       = io_deq_valid & io_deq_ready & ~empty;

  always_comb begin
    io_deq_bits = '0;
    if (!empty) begin
      io_deq_bits = mem_R0_data;
    end else if (FLOW_EN && io_enq_valid) begin
      io_deq_bits = io_enq_bits;
    end
  end

  always_comb begin
    enq_ptr_d    = enq_ptr_q;
    deq_ptr_d    = deq_ptr_q;
    maybe_full_d = maybe_full_q;
    if (do_enq) begin
      enq_ptr_d = (enq_ptr_q == LAST) ? 5'd0 : enq_ptr_q + 5'd1;
    end
    if (do_deq) begin
      deq_ptr_d = (deq_ptr_q == LAST) ? 5'd0 : deq_ptr_q + 5'd1;
    end
    if (do_enq != do_deq) begin
      maybe_full_d = do_enq;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      enq_ptr_q    <= '0;
      deq_ptr_q    <= '0;
      maybe_full_q <= 1'b0;
    end else begin
      enq_ptr_q    <= enq_ptr_d;
      deq_ptr_q    <= deq_ptr_d;
      maybe_full_q <= maybe_full_d;
    end
  end

  always_comb begin
    count_w = '0;
    if (full) begin
      count_w = DEPTH_W;
    end else if (enq_ptr_q >= deq_ptr_q) begin
      count_w = {1'b0, enq_ptr_q} - {1'b0, deq_ptr_q};
    end else begin
      count_w = DEPTH_W + {1'b0, enq_ptr_q} - {1'b0, deq_ptr_q};
    end
  end

  assign io_count    = count_w[4:0];
  assign mem_W0_addr = enq_ptr_q;
  assign mem_W0_en   = do_enq;
  assign mem_W0_clk  = clock;
  assign mem_W0_data = io_enq_bits;
  assign mem_R0_addr = deq_ptr_q;
  assign mem_R0_en   = ~empty;
  assign mem_R0_clk  = clock;

endmodule
